// File: rtl/uart_pkg.sv
// Shared types and constants for the serial console receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is presented whenever not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             rd_ok;
  logic             wr_ok;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when the head is leaving in the same cycle.
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);
  assign head  = mem[rd_ptr];

  // Storage is plain data and carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_line_rx.sv
// 8N1 console receiver: synchronizer, deframer FSM, receive FIFO and
// framing/overrun/end-of-line pulse flags.
module uart_line_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       line_done
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  logic       rx_p0;
  logic       rx_p1;
  logic       rx_p2;
  rx_state_t  state;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;

  logic       tick;
  logic       fall;
  logic       push;
  logic       stop_bad;
  logic       pop;
  logic       push_ok;
  logic       drop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  assign tick     = (cnt == 16'd0);
  assign fall     = rx_p2 && !rx_p1;
  assign push     = (state == STOP) && tick && rx_p1;
  assign stop_bad = (state == STOP) && tick && !rx_p1;
  assign pop      = rd_en && !fifo_empty;
  assign push_ok  = push && (!fifo_full || pop);
  assign drop     = push && fifo_full && !pop;

  // Stage p0/p1: metastability synchronizer; p2: previous value for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Deframer: counts down to each mid-bit sample point from the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= HALF_M1;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_p1) begin
              state <= IDLE;
            end else begin
              cnt     <= DIV_M1;
              bit_idx <= 3'd0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt     <= DIV_M1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (tick) state <= rx_p1 ? IDLE : WAIT_HIGH;
          else      cnt   <= cnt - 16'd1;
        end
        WAIT_HIGH: begin
          // Hold off until a break or stuck-low line releases.
          if (rx_p1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LSB-first data shift register, sampled at each data-bit midpoint.
  always_ff @(posedge clk) begin
    if (state == DATA && tick) shift <= {rx_p1, shift[7:1]};
  end

  // Single-cycle status pulses, one cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      line_done <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= drop;
      line_done <= push_ok && (shift == ASCII_LF);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_uart_line_rx.sv
// Self-checking bench for uart_line_rx at 27 MHz / 115200 baud.
`timescale 1ns/1ps
module tb_uart_line_rx;
  import uart_pkg::*;

  localparam int DIV         = 234;
  localparam int HALF        = 117;
  localparam int STOP_SAMPLE = HALF + 9 * DIV;
  localparam int SYNC_LAT    = 3;
  localparam int FRAME       = 10 * DIV;
  localparam int DEPTH       = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;
  logic       line_done;

  uart_line_rx #(
    .CLK_HZ     (27_000_000),
    .BAUD       (115_200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .line_done (line_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int ld_cnt   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_line;
  } vec_t;
  vec_t vecs[4];

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (line_done) ld_cnt++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < DEPTH + 2 && rd_valid; i++) begin
      check({name, "_data"}, rd_data, (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100);
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
    end
    check({name, "_empty"}, rd_valid, 0);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int fe0, ov0, ld0;
    logic [7:0] hello [7];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
    vecs[0] = '{8'h0A, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0};

    rst = 1'b1; uart_rx = 1'b1; rd_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", {frame_err, overrun, line_done}, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    idle(20);
    check("rel_pulses", fe_cnt + ov_cnt + ld_cnt, 0);

    // Pop while empty must not disturb anything.
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    check("empty_pop", rd_valid, 0);

    // Single byte with exact push timing.
    exp_q.push_back(8'h48);
    fork
      send_frame(8'h48, 1'b1);
      begin
        repeat (SYNC_LAT + STOP_SAMPLE - 1) @(posedge clk);
        #1;
        check("t1_pre_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        check("t1_valid", rd_valid, 1);
        check("t1_line", line_done, 0);
      end
    join
    drain("t1");

    // Table of single frames.
    for (int v = 0; v < 4; v++) begin
      fe0 = fe_cnt; ld0 = ld_cnt;
      if (vecs[v].stop_ok) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_ok);
      idle(DIV);
      check($sformatf("vec%0d_valid", v), rd_valid, 32'(vecs[v].stop_ok));
      check($sformatf("vec%0d_line", v), ld_cnt - ld0, 32'(vecs[v].exp_line));
      check($sformatf("vec%0d_ferr", v), fe_cnt - fe0, 32'(!vecs[v].stop_ok));
      drain($sformatf("vec%0d", v));
    end

    // "Hello\r\n" back to back, nothing read until the end.
    ld0 = ld_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(hello[i]);
      send_frame(hello[i], 1'b1);
      if (i == 5) check("hello_no_early_line", ld_cnt - ld0, 0);
    end
    idle(5);
    check("hello_line_once", ld_cnt - ld0, 1);
    check("hello_no_ovr", ov_cnt - ov0, 0);
    drain("hello");

    // 50-cycle glitch is rejected at the start-bit midpoint.
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (SYNC_LAT + HALF - 1 - 50) @(posedge clk);
    #1;
    check("glitch_in_start", 32'(dut.state), 32'(START));
    @(posedge clk);
    #1;
    check("glitch_idle", 32'(dut.state), 32'(IDLE));
    idle(DIV);
    check("glitch_no_push", rd_valid, 0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);

    // Stop bit held low for three bit times, then a good byte.
    fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i[0]);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle(DIV);
    check("break_ferr", fe_cnt - fe0, 1);
    check("break_no_push", rd_valid, 0);
    check("break_state", 32'(dut.state), 32'(IDLE));
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(5);
    check("break_ferr_once", fe_cnt - fe0, 1);
    drain("after_break");

    // Nine bytes, no reads: the ninth is dropped.
    ov0 = ov_cnt;
    for (int i = 1; i <= 9; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      if (i == DEPTH) check("ovr_none_yet", ov_cnt - ov0, 0);
    end
    idle(5);
    check("ovr_once", ov_cnt - ov0, 1);
    drain("ovr");

    // Same, with a pop landing on the ninth push cycle.
    ov0 = ov_cnt;
    for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
    fork
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
      begin
        repeat (DEPTH * FRAME + SYNC_LAT + STOP_SAMPLE - 1) @(posedge clk);
        #1;
        check("fullpop_head", rd_data, (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    idle(5);
    check("fullpop_no_ovr", ov_cnt - ov0, 0);
    drain("fullpop");

    // Reset in the middle of data bit 4, with a byte already buffered.
    send_frame(8'h11, 1'b1);
    check("pre_rst_valid", rd_valid, 1);
    fe0 = fe_cnt; ov0 = ov_cnt; ld0 = ld_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i >= 2);
    uart_rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    idle(DIV);
    check("post_rst_pulses", (fe_cnt - fe0) + (ov_cnt - ov0) + (ld_cnt - ld0), 0);
    check("post_rst_valid", rd_valid, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(5);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
